lsu_addr_queue: RTL and testbench
=================================

LSU_ADDR_QUEUE -- requirements
Module: lsu_addr_queue

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, width of base-register operand.
REQ-002 SHALL provide parameter IMM_W, default 4, width of immediate field.
REQ-003 SHALL provide parameter ADDR_W, default 10, width of computed address carried on CDB.
REQ-004 SHALL provide parameter NUM_REGS, default 3, number of architectural registers; dest field one-hot of this width.
REQ-005 SHALL provide parameter RSP_W, default 2, width of reservation-station position tag.
REQ-006 SHALL provide parameter DEPTH, default 4, request queue entries; power of two, >=2.
REQ-007 SHALL provide parameter IMM_SIGNED, default 0, 1 = sign-extend immediate, 0 = zero-extend.
REQ-008 SHALL have ports: clock  in  1  rising-edge clock; reset_n  in  1  synchronous active-low reset.
REQ-009 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  queue can accept.
REQ-010 SHALL have ports: ry_data  in  DATA_W  base; imm  in  IMM_W  offset; reg_dest  in  3  dest index; ula_op  in  3  opcode; rs_position  in  RSP_W  RS slot.
REQ-011 SHALL have ports: cdb_req  out  1  result pending; cdb_grant  in  1  arbiter accepts result; cdb_out  out  NUM_REGS+RSP_W+1+ADDR_W  packet.
REQ-012 SHALL have ports: occupancy  out  $clog2(DEPTH)+1  queued entries; err_illegal  out  1  one-cycle pulse on dropped request.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid && in_ready, writing it to the queue tail.
REQ-014 SHALL drive in_ready = (occupancy < DEPTH); no bypass when full, even if a pop occurs same cycle.
REQ-015 SHALL compute address = (ry_data + ext(imm)) truncated to ADDR_W bits, modulo 2^ADDR_W (wrap-around, no overflow flag).
REQ-016 SHALL form cdb_out = {dest_onehot, rs_position, 1'b0 unit id, address}, MSB first; dest bit NUM_REGS-1-k set for reg_dest = k.
REQ-017 SHALL, for ula_op 3'b010 (load), set exactly one dest bit per reg_dest.
REQ-018 SHALL, for ula_op 3'b011 (store), set all dest bits zero regardless of reg_dest.
REQ-019 SHALL treat any other ula_op, or a load with reg_dest >= NUM_REGS, as illegal: drop at queue head with no CDB request and pulse err_illegal for exactly one cycle.
REQ-020 SHALL pop the queue head into the output register on an edge where the queue is non-empty and (cdb_req == 0 or cdb_grant == 1).
REQ-021 SHALL assert cdb_req while the output register holds a result and hold cdb_out stable until the edge where cdb_grant is sampled high.
REQ-022 SHALL ignore cdb_grant when cdb_req is 0.
REQ-023 SHALL drive cdb_out all ones whenever cdb_req is 0.
REQ-024 SHALL give latency of 2 edges: request accepted at edge N into an empty unit -> cdb_req high after edge N+1.
REQ-025 SHALL sustain one result per cycle under continuous grant, back-to-back grant-and-reload with no bubble.
REQ-026 SHALL handle simultaneous push and pop (not full): occupancy unchanged, FIFO order preserved.
REQ-027 SHALL update occupancy on every edge: +1 push, -1 pop, 0 for both or neither.
REQ-028 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-029 SHALL, on an edge with reset_n low, clear occupancy and pointers to 0, cdb_req and err_illegal to 0, cdb_out to all ones; in_ready = 1 after reset.
REQ-030 SHALL discard queued and pending results on reset mid-operation; no cdb_req until new requests arrive after reset_n high.
REQ-031 SHALL give reset priority over push, pop and grant in the same cycle.

Verification
REQ-032 Load: ry_data=16'h0005, imm=4'h3, reg_dest=1, op=010, rs=2'b10, grant held 1 -> after 2 edges cdb_out=16'b010_10_0_0000001000, cdb_req=1 one cycle.
REQ-033 Store wrap: ry_data=16'h03FF, imm=4'h2, reg_dest=0, op=011, rs=0 -> cdb_out=16'b000_00_0_0000000001; IMM_SIGNED=1, imm=4'hF, ry_data=5 -> addr 4.
REQ-034 Backpressure: push 5 loads with grant=0, DEPTH=4 -> one in output reg, 4 queued, in_ready=0, cdb_out stable; release grant -> 5 results in issue order on consecutive cycles.
REQ-035 Illegal: op=3'b111 between two loads -> err_illegal pulses once, only two CDB results, order preserved.
REQ-036 Reset: reset_n low with 3 queued and cdb_req=1 -> next edge occupancy=0, cdb_req=0, cdb_out=all ones, in_ready=1.

Source files
------------

// File: rtl/lsu_addr_queue.sv
// Load/store address unit: computes base + immediate, queues the resulting
// CDB packets in a small FIFO and presents them one at a time to the CDB
// arbiter through a single output register.
module lsu_addr_queue #(
    parameter int DATA_W     = 16,
    parameter int IMM_W      = 4,
    parameter int ADDR_W     = 10,
    parameter int NUM_REGS   = 3,
    parameter int RSP_W      = 2,
    parameter int DEPTH      = 4,
    parameter int IMM_SIGNED = 0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                ry_data,
    input  logic [IMM_W-1:0]                 imm,
    input  logic [2:0]                       reg_dest,
    input  logic [2:0]                       ula_op,
    input  logic [RSP_W-1:0]                 rs_position,
    output logic                             cdb_req,
    input  logic                             cdb_grant,
    output logic [NUM_REGS+RSP_W+ADDR_W:0]   cdb_out,
    output logic [$clog2(DEPTH):0]           occupancy,
    output logic                             err_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = NUM_REGS + RSP_W + 1 + ADDR_W;

    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;

    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   sum;
    logic [NUM_REGS-1:0] dest_oh;
    logic                is_load;
    logic                is_store;
    logic                legal;
    logic [PKT_W-1:0]    in_pkt;

    // Each entry carries a legality flag in its MSB so illegal requests can
    // be dropped at the head rather than rejected at the input.
    logic [PKT_W:0]      mem [DEPTH];
    logic [PKT_W:0]      head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PKT_W-1:0]    out_reg;
    logic                push;
    logic                pop;

    // Address computation and packet formation for the incoming request
    always_comb begin
        imm_ext  = (IMM_SIGNED != 0) ? DATA_W'($signed(imm)) : DATA_W'(imm);
        sum      = ry_data + imm_ext;
        is_load  = (ula_op == OP_LOAD);
        is_store = (ula_op == OP_STORE);
        legal    = is_store || (is_load && (32'(reg_dest) < NUM_REGS));
        dest_oh  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (is_load && (32'(reg_dest) == k)) begin
                dest_oh[NUM_REGS-1-k] = 1'b1;
            end
        end
        in_pkt   = {dest_oh, rs_position, 1'b0, sum[ADDR_W-1:0]};
    end

    // Handshake decode; a full queue never bypasses even when popping
    always_comb begin
        in_ready = (occupancy < CNT_W'(DEPTH));
        push     = in_valid && in_ready;
        pop      = (occupancy != '0) && (!cdb_req || cdb_grant);
        head     = mem[rd_ptr];
        cdb_out  = cdb_req ? out_reg : '1;
    end

    // Queue storage; stale contents are harmless because pointers reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {legal, in_pkt};
        end
    end

    // Pointers, occupancy, output register and error pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            cdb_req     <= 1'b0;
            out_reg     <= '1;
            err_illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            err_illegal <= pop && !head[PKT_W];
            if (pop) begin
                cdb_req <= head[PKT_W];
                if (head[PKT_W]) begin
                    out_reg <= head[PKT_W-1:0];
                end
            end else if (cdb_grant) begin
                cdb_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_addr_queue.sv
// Directed bench for lsu_addr_queue: a zero-extending instance plus a
// sign-extending instance sharing the same stimulus.
module tb_lsu_addr_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ry_data;
    logic [3:0]  imm;
    logic [2:0]  reg_dest;
    logic [2:0]  ula_op;
    logic [1:0]  rs_position;
    logic        cdb_req;
    logic        cdb_grant;
    logic [15:0] cdb_out;
    logic [2:0]  occupancy;
    logic        err_illegal;

    logic        s_in_ready;
    logic        s_cdb_req;
    logic [15:0] s_cdb_out;
    logic [2:0]  s_occupancy;
    logic        s_err_illegal;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    lsu_addr_queue dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ry_data(ry_data), .imm(imm), .reg_dest(reg_dest), .ula_op(ula_op),
        .rs_position(rs_position), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_out(cdb_out), .occupancy(occupancy), .err_illegal(err_illegal)
    );

    lsu_addr_queue #(.IMM_SIGNED(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .ry_data(ry_data), .imm(imm), .reg_dest(reg_dest), .ula_op(ula_op),
        .rs_position(rs_position), .cdb_req(s_cdb_req), .cdb_grant(cdb_grant),
        .cdb_out(s_cdb_out), .occupancy(s_occupancy), .err_illegal(s_err_illegal)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] i, input logic [2:0] dst,
                         input logic [2:0] op, input logic [1:0] rs);
        in_valid    = 1'b1;
        ry_data     = d;
        imm         = i;
        reg_dest    = dst;
        ula_op      = op;
        rs_position = rs;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        cdb_grant = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        vectors++; if (cdb_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", cdb_req); end
        vectors++; if (cdb_out !== 16'hFFFF) begin miscompares++; $display("FAIL reset_out got %h want ffff", cdb_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
        vectors++; if (err_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_illegal); end
    endtask

    task automatic test_load();
        do_reset();
        cdb_grant = 1'b1;
        drive(16'h0005, 4'h3, 3'd1, 3'b010, 2'b10);
        tick();
        in_valid = 1'b0;
        vectors++; if (cdb_req !== 1'b0) begin miscompares++; $display("FAIL load_lat1 got %b want 0", cdb_req); end
        vectors++; if (occupancy !== 3'd1) begin miscompares++; $display("FAIL load_occ got %0d want 1", occupancy); end
        tick();
        vectors++; if (cdb_req !== 1'b1) begin miscompares++; $display("FAIL load_req got %b want 1", cdb_req); end
        vectors++; if (cdb_out !== 16'h5008) begin miscompares++; $display("FAIL load_out got %h want 5008", cdb_out); end
        tick();
        vectors++; if (cdb_req !== 1'b0) begin miscompares++; $display("FAIL load_drop got %b want 0", cdb_req); end
        vectors++; if (cdb_out !== 16'hFFFF) begin miscompares++; $display("FAIL load_idle got %h want ffff", cdb_out); end
    endtask

    task automatic test_store_wrap();
        do_reset();
        cdb_grant = 1'b1;
        drive(16'h03FF, 4'h2, 3'd0, 3'b011, 2'b00);
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (cdb_req !== 1'b1) begin miscompares++; $display("FAIL store_req got %b want 1", cdb_req); end
        vectors++; if (cdb_out !== 16'h0001) begin miscompares++; $display("FAIL store_out got %h want 0001", cdb_out); end
        tick();
    endtask

    task automatic test_signed_imm();
        do_reset();
        cdb_grant = 1'b1;
        drive(16'h0005, 4'hF, 3'd2, 3'b010, 2'b01);
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (cdb_out !== 16'h2814) begin miscompares++; $display("FAIL zext_out got %h want 2814", cdb_out); end
        vectors++; if (s_cdb_out !== 16'h2804) begin miscompares++; $display("FAIL sext_out got %h want 2804", s_cdb_out); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_pkt [5];
        exp_pkt = '{16'h8100, 16'h4901, 16'h3102, 16'h9903, 16'h4104};
        do_reset();
        cdb_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(16'h0100 + 16'(i), 4'h0, 3'(i % 3), 3'b010, 2'(i));
            tick();
        end
        vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL bp_occ got %0d want 4", occupancy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready got %b want 0", in_ready); end
        vectors++; if (cdb_out !== exp_pkt[0]) begin miscompares++; $display("FAIL bp_hold got %h want %h", cdb_out, exp_pkt[0]); end
        drive(16'h0200, 4'h0, 3'd0, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        vectors++; if (occupancy !== 3'd4) begin miscompares++; $display("FAIL bp_full_push got %0d want 4", occupancy); end
        vectors++; if (cdb_out !== exp_pkt[0]) begin miscompares++; $display("FAIL bp_stable got %h want %h", cdb_out, exp_pkt[0]); end
        cdb_grant = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            vectors++; if (cdb_req !== 1'b1 || cdb_out !== exp_pkt[i]) begin
                miscompares++; $display("FAIL bp_drain%0d got req=%b out=%h want req=1 out=%h", i, cdb_req, cdb_out, exp_pkt[i]);
            end
        end
        tick();
        vectors++; if (cdb_req !== 1'b0 || occupancy !== 3'd0) begin
            miscompares++; $display("FAIL bp_empty got req=%b occ=%0d want req=0 occ=0", cdb_req, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pkt [4];
        exp_pkt = '{16'h8100, 16'h4901, 16'h3102, 16'h9903};
        do_reset();
        cdb_grant = 1'b1;
        drive(16'h0100, 4'h0, 3'd0, 3'b010, 2'd0);
        tick();
        for (int i = 1; i < 5; i++) begin
            if (i < 4) drive(16'h0100 + 16'(i), 4'h0, 3'(i % 3), 3'b010, 2'(i));
            else in_valid = 1'b0;
            tick();
            vectors++; if (cdb_req !== 1'b1 || cdb_out !== exp_pkt[i-1]) begin
                miscompares++; $display("FAIL b2b_out%0d got req=%b out=%h want req=1 out=%h", i-1, cdb_req, cdb_out, exp_pkt[i-1]);
            end
            vectors++; if (occupancy !== ((i < 4) ? 3'd1 : 3'd0)) begin
                miscompares++; $display("FAIL b2b_occ%0d got %0d want %0d", i, occupancy, (i < 4) ? 1 : 0);
            end
        end
        tick();
        vectors++; if (cdb_req !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", cdb_req); end
    endtask

    task automatic test_illegal();
        do_reset();
        cdb_grant = 1'b1;
        drive(16'h0020, 4'h1, 3'd0, 3'b010, 2'd1);
        tick();
        drive(16'h0000, 4'h0, 3'd0, 3'b111, 2'd0);
        tick();
        vectors++; if (cdb_req !== 1'b1 || cdb_out !== 16'h8821 || err_illegal !== 1'b0) begin
            miscompares++; $display("FAIL ill_a got req=%b out=%h err=%b want 1 8821 0", cdb_req, cdb_out, err_illegal);
        end
        drive(16'h0030, 4'h2, 3'd2, 3'b010, 2'd3);
        tick();
        in_valid = 1'b0;
        vectors++; if (cdb_req !== 1'b0 || cdb_out !== 16'hFFFF || err_illegal !== 1'b1) begin
            miscompares++; $display("FAIL ill_drop got req=%b out=%h err=%b want 0 ffff 1", cdb_req, cdb_out, err_illegal);
        end
        tick();
        vectors++; if (cdb_req !== 1'b1 || cdb_out !== 16'h3832 || err_illegal !== 1'b0) begin
            miscompares++; $display("FAIL ill_b got req=%b out=%h err=%b want 1 3832 0", cdb_req, cdb_out, err_illegal);
        end
        tick();
        vectors++; if (cdb_req !== 1'b0 || err_illegal !== 1'b0) begin
            miscompares++; $display("FAIL ill_end got req=%b err=%b want 0 0", cdb_req, err_illegal);
        end
        drive(16'h0040, 4'h0, 3'd5, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (cdb_req !== 1'b0 || err_illegal !== 1'b1) begin
            miscompares++; $display("FAIL ill_dest got req=%b err=%b want 0 1", cdb_req, err_illegal);
        end
        tick();
        vectors++; if (err_illegal !== 1'b0) begin miscompares++; $display("FAIL ill_pulse got %b want 0", err_illegal); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(16'h0100 + 16'(i), 4'h0, 3'(i % 3), 3'b010, 2'(i));
            tick();
        end
        vectors++; if (occupancy !== 3'd3 || cdb_req !== 1'b1) begin
            miscompares++; $display("FAIL rm_pre got occ=%0d req=%b want 3 1", occupancy, cdb_req);
        end
        reset_n   = 1'b0;
        cdb_grant = 1'b1;
        tick();
        vectors++; if (occupancy !== 3'd0 || cdb_req !== 1'b0 || cdb_out !== 16'hFFFF || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rm_reset got occ=%0d req=%b out=%h rdy=%b want 0 0 ffff 1", occupancy, cdb_req, cdb_out, in_ready);
        end
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        cdb_grant = 1'b0;
        tick();
        tick();
        vectors++; if (occupancy !== 3'd0 || cdb_req !== 1'b0) begin
            miscompares++; $display("FAIL rm_after got occ=%0d req=%b want 0 0", occupancy, cdb_req);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        ry_data     = '0;
        imm         = '0;
        reg_dest    = '0;
        ula_op      = '0;
        rs_position = '0;
        cdb_grant   = 1'b0;
        #1;
        test_reset();
        test_load();
        test_store_wrap();
        test_signed_imm();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
